jk_bank_ctrl: RTL and testbench

Shared-access controller for a bank of N positive-edge JK flip-flops. Two requesters issue JK commands (hold, reset, set, toggle) through valid/ready handshakes, and a round-robin arbiter serialises them. A command targets either one flop, or every flop in sequence (a "sweep", one flop per cycle). The block sits between control logic and the flag/status bits it drives; `q` is the bank state.

---
 rtl/jk_bank_ctrl.sv | 178 +++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl
// Shared-access controller for a bank of N JK flip-flops. Two requesters
// (A and B) issue hold/clear/set/toggle commands through valid/ready
// handshakes; a round-robin arbiter picks one per cycle. A command either
// targets a single flop or sweeps the whole bank, one flop per cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   a_valid/a_ready          requester A handshake
//   a_idx, a_j, a_k, a_all   requester A payload (target, JK, sweep flag)
//   b_*                      same for requester B
//   q                        bank state
//   busy                     sweep in progress
//   idx_err                  one-cycle pulse after an out-of-range single command
module jk_bank_ctrl #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [IDX_W-1:0] a_idx,
    input  logic             a_j,
    input  logic             a_k,
    input  logic             a_all,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [IDX_W-1:0] b_idx,
    input  logic             b_j,
    input  logic             b_k,
    input  logic             b_all,
    output logic [N-1:0]     q,
    output logic             busy,
    output logic             idx_err
);

    typedef enum logic {IDLE, SWEEP} state_t;

    // One extra counter bit lets N == 2**IDX_W be compared without wrapping
    localparam logic [IDX_W:0] N_VAL = (IDX_W+1)'(N);
    localparam logic [IDX_W:0] LAST  = (IDX_W+1)'(N-1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W:0]   cnt;
    logic             last_grant;
    logic             sweep_j;
    logic             sweep_k;
    logic             grant_a;
    logic             grant_b;
    logic             xfer_a;
    logic             xfer_b;
    logic             xfer;
    logic [IDX_W-1:0] xfer_idx;
    logic             xfer_j;
    logic             xfer_k;
    logic             xfer_all;
    logic             idx_bad;
    logic             upd_en;
    logic [IDX_W:0]   upd_idx;
    logic             upd_j;
    logic             upd_k;

    // JK next-state rule: 00 hold, 01 clear, 10 set, 11 invert
    function automatic logic jk_next(input logic cur, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            2'b00:   nxt = cur;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            default: nxt = ~cur;
        endcase
        return nxt;
    endfunction

    // Round-robin arbitration: on a tie the requester that did not win last time
    // is granted. last_grant is 0 for A, 1 for B.
    always_comb begin
        grant_a = a_valid && (!b_valid || last_grant);
        grant_b = b_valid && (!a_valid || !last_grant);
    end

    // Payload of whichever requester transfers this cycle
    assign xfer_a   = a_valid && a_ready;
    assign xfer_b   = b_valid && b_ready;
    assign xfer     = xfer_a || xfer_b;
    assign xfer_idx = xfer_b ? b_idx : a_idx;
    assign xfer_j   = xfer_b ? b_j   : a_j;
    assign xfer_k   = xfer_b ? b_k   : a_k;
    assign xfer_all = xfer_b ? b_all : a_all;
    assign idx_bad  = xfer && !xfer_all && ({1'b0, xfer_idx} >= N_VAL);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic: a sweep transfer enters SWEEP, the last flop exits it
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (xfer && xfer_all) next_state = SWEEP;
            SWEEP:   if (cnt == LAST)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: readies only in IDLE and never while reset is held
    always_comb begin
        busy    = (state == SWEEP);
        a_ready = !rst && (state == IDLE) && grant_a;
        b_ready = !rst && (state == IDLE) && grant_b;
    end

    // Select which flop (if any) is written this cycle and with which JK pair
    always_comb begin
        upd_en  = 1'b0;
        upd_idx = '0;
        upd_j   = 1'b0;
        upd_k   = 1'b0;
        if (state == SWEEP) begin
            upd_en  = 1'b1;
            upd_idx = cnt;
            upd_j   = sweep_j;
            upd_k   = sweep_k;
        end else if (xfer) begin
            upd_en  = !idx_bad;
            upd_idx = xfer_all ? '0 : {1'b0, xfer_idx};
            upd_j   = xfer_j;
            upd_k   = xfer_k;
        end
    end

    // Control registers: sweep counter, latched sweep command, arbiter history,
    // and the registered index-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            sweep_j    <= 1'b0;
            sweep_k    <= 1'b0;
            idx_err    <= 1'b0;
        end else begin
            idx_err <= idx_bad;
            if (xfer) begin
                last_grant <= xfer_b;
            end
            if (state == IDLE) begin
                if (xfer && xfer_all) begin
                    cnt     <= (IDX_W+1)'(1);
                    sweep_j <= xfer_j;
                    sweep_k <= xfer_k;
                end
            end else begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    // Flop bank: only the selected flop changes, all others hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (upd_en && int'(upd_idx) == i) begin
                    q[i] <= jk_next(q[i], upd_j, upd_k);
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl
// Directed testbench for jk_bank_ctrl. Three instances share clock and reset:
// the default N=8 bank, an N=6 bank for out-of-range indices, and an N=2 bank
// for the shortest sweep.
module tb_jk_bank_ctrl;

    logic clk;
    logic rst;

    logic       a_valid, a_ready, a_j, a_k, a_all;
    logic       b_valid, b_ready, b_j, b_k, b_all;
    logic [2:0] a_idx, b_idx;
    logic [7:0] q;
    logic       busy, idx_err;

    logic       s_a_valid, s_a_ready, s_a_j, s_a_k, s_a_all;
    logic       s_b_valid, s_b_ready, s_b_j, s_b_k, s_b_all;
    logic [2:0] s_a_idx, s_b_idx;
    logic [5:0] s_q;
    logic       s_busy, s_idx_err;

    logic       t_a_valid, t_a_ready, t_a_j, t_a_k, t_a_all;
    logic       t_b_valid, t_b_ready, t_b_j, t_b_k, t_b_all;
    logic [0:0] t_a_idx, t_b_idx;
    logic [1:0] t_q;
    logic       t_busy, t_idx_err;

    int vectors;
    int miscompares;

    jk_bank_ctrl #(.N(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_j(a_j), .a_k(a_k), .a_all(a_all),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_j(b_j), .b_k(b_k), .b_all(b_all),
        .q(q), .busy(busy), .idx_err(idx_err)
    );

    jk_bank_ctrl #(.N(6), .IDX_W(3)) dut6 (
        .clk(clk), .rst(rst),
        .a_valid(s_a_valid), .a_ready(s_a_ready), .a_idx(s_a_idx), .a_j(s_a_j), .a_k(s_a_k), .a_all(s_a_all),
        .b_valid(s_b_valid), .b_ready(s_b_ready), .b_idx(s_b_idx), .b_j(s_b_j), .b_k(s_b_k), .b_all(s_b_all),
        .q(s_q), .busy(s_busy), .idx_err(s_idx_err)
    );

    jk_bank_ctrl #(.N(2), .IDX_W(1)) dut2 (
        .clk(clk), .rst(rst),
        .a_valid(t_a_valid), .a_ready(t_a_ready), .a_idx(t_a_idx), .a_j(t_a_j), .a_k(t_a_k), .a_all(t_a_all),
        .b_valid(t_b_valid), .b_ready(t_b_ready), .b_idx(t_b_idx), .b_j(t_b_j), .b_k(t_b_k), .b_all(t_b_all),
        .q(t_q), .busy(t_busy), .idx_err(t_idx_err)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive both requesters of the N=8 instance, then let combinational paths settle
    task automatic applyStimulus(
        input logic av, input logic [2:0] ai, input logic aj, input logic ak, input logic aa,
        input logic bv, input logic [2:0] bi, input logic bj, input logic bk, input logic ba);
        a_valid = av; a_idx = ai; a_j = aj; a_k = ak; a_all = aa;
        b_valid = bv; b_idx = bi; b_j = bj; b_k = bk; b_all = ba;
        #1;
    endtask

    // Single comparison point: counts the vector and reports any miscompare
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus and expected-value tables
    logic [1:0] t1_jk [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    logic [7:0] t1_q  [5] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h00};
    logic [7:0] t2_q  [4] = '{8'h01, 8'h03, 8'h03, 8'h03};
    logic [2:0] t3_idx[4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [1:0] t3_jk [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    logic [7:0] sw_q  [8] = '{8'hA4, 8'hA6, 8'hA2, 8'hAA, 8'hBA, 8'h9A, 8'hDA, 8'h5A};

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        s_a_valid = 0; s_a_idx = 0; s_a_j = 0; s_a_k = 0; s_a_all = 0;
        s_b_valid = 0; s_b_idx = 0; s_b_j = 0; s_b_k = 0; s_b_all = 0;
        t_a_valid = 0; t_a_idx = 0; t_a_j = 0; t_a_k = 0; t_a_all = 0;
        t_b_valid = 0; t_b_idx = 0; t_b_j = 0; t_b_k = 0; t_b_all = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state, with A requesting while reset is held
        #1 rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_q", q, 8'h00);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_idx_err", idx_err, 0);
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_b_ready", b_ready, 0);
        checkOutput("rst_q6", s_q, 6'h00);
        checkOutput("rst_q2", t_q, 2'b00);
        step();
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back single commands from A on idx 3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 3'd3, t1_jk[i][1], t1_jk[i][0], 0, 0, 0, 0, 0, 0);
            checkOutput("t1_a_ready", a_ready, 1);
            step();
            checkOutput("t1_q", q, t1_q[i]);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fresh reset so A wins the first tie, then alternate A/B grants
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1, 3'd0, 1, 0, 0, 1, 3'd1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            checkOutput("t2_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
            step();
            checkOutput("t2_q", q, t2_q[i]);
        end

        // Build q = A5 with single commands from A
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, t3_idx[i], t3_jk[i][1], t3_jk[i][0], 0, 0, 0, 0, 0, 0);
            step();
        end
        checkOutput("t3_q_init", q, 8'hA5);

        // B sweeps with toggle while A holds a request throughout
        applyStimulus(1, 3'd0, 0, 0, 0, 1, 3'd0, 1, 1, 1);
        checkOutput("t3_b_ready", b_ready, 1);
        checkOutput("t3_a_ready", a_ready, 0);
        step();
        applyStimulus(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            checkOutput("t3_sweep_q", q, sw_q[i]);
            checkOutput("t3_busy", busy, (i < 7) ? 1 : 0);
            checkOutput("t3_sweep_a_ready", a_ready, (i == 7) ? 1 : 0);
        end
        step();
        checkOutput("t3_after_hold_q", q, 8'h5A);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Out-of-range single command on the N=6 bank, then an in-range one
        s_a_valid = 1; s_a_idx = 3'd7; s_a_j = 1; s_a_k = 0;
        #1;
        checkOutput("t4_a_ready", s_a_ready, 1);
        step();
        s_a_valid = 0;
        checkOutput("t4_q", s_q, 6'h00);
        checkOutput("t4_idx_err_hi", s_idx_err, 1);
        step();
        checkOutput("t4_idx_err_lo", s_idx_err, 0);
        s_a_valid = 1; s_a_idx = 3'd5;
        step();
        s_a_valid = 0;
        checkOutput("t4_q_ok", s_q, 6'h20);
        checkOutput("t4_idx_err_ok", s_idx_err, 0);

        // Set-all sweep aborted by reset before edge t+3
        applyStimulus(1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t5_a_ready", a_ready, 1);
        step();
        checkOutput("t5_busy", busy, 1);
        applyStimulus(1, 3'd4, 1, 0, 0, 1, 3'd6, 1, 0, 0);
        step();
        step();
        checkOutput("t5_q_partial", q, 8'h5F);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_rst_q", q, 8'h00);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_a_ready", a_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("t5_tie_a_ready", a_ready, 1);
        checkOutput("t5_tie_b_ready", b_ready, 0);
        step();
        checkOutput("t5_q_a", q, 8'h10);
        checkOutput("t5_next_b_ready", b_ready, 1);
        step();
        checkOutput("t5_q_b", q, 8'h50);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // N=2 toggle sweep from 01, next request accepted at the third edge
        t_a_valid = 1; t_a_idx = 1'b0; t_a_j = 1; t_a_k = 0; t_a_all = 0;
        step();
        checkOutput("t6_q_init", t_q, 2'b01);
        t_a_j = 1; t_a_k = 1; t_a_all = 1;
        #1;
        checkOutput("t6_sweep_ready", t_a_ready, 1);
        step();
        checkOutput("t6_q_edge1", t_q, 2'b00);
        checkOutput("t6_busy1", t_busy, 1);
        t_a_j = 1; t_a_k = 0; t_a_all = 0;
        #1;
        checkOutput("t6_ready_busy", t_a_ready, 0);
        step();
        checkOutput("t6_q_edge2", t_q, 2'b10);
        checkOutput("t6_busy2", t_busy, 0);
        checkOutput("t6_ready_free", t_a_ready, 1);
        step();
        t_a_valid = 0;
        checkOutput("t6_q_edge3", t_q, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
